pipelined_barrel_shifter: RTL and testbench

- Parametrised, pipelined, multi-mode barrel shifter for the ALU datapath. Successor to the single-cycle combinational left, logical-right and arithmetic-right shifters.
- Implements a log2(WIDTH)-level shift network. Its levels are split across PIPE_STAGES register stages.
- Valid/ready handshake on input and output, with full backpressure, so the block can sit between pipelined issue and writeback.

---
 rtl/pipelined_barrel_shifter_if.sv | 33 +++
 rtl/pipelined_barrel_shifter.sv | 146 ++++++++++++++
 tb/tb_pipelined_barrel_shifter.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipelined_barrel_shifter_if.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_barrel_shifter_if
// Brief    : Operation/result handshake bundle for pipelined_barrel_shifter.
// Revision : 1.0  initial release
// ============================================================================
interface pipelined_barrel_shifter_if #(
    parameter int WIDTH = 32
);
    localparam int SHW = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [SHW-1:0]   in_shamt;
    logic [1:0]       in_op;
    logic [3:0]       in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [3:0]       out_tag;

    modport master (
        output in_valid, in_data, in_shamt, in_op, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag
    );

    modport slave (
        input  in_valid, in_data, in_shamt, in_op, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag
    );
endinterface
`default_nettype wire

// File: rtl/pipelined_barrel_shifter.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_barrel_shifter
// Brief    : log2(WIDTH)-level SLL/SRL/SRA/ROR shifter split over PIPE_STAGES
//            register stages with valid/ready backpressure.
//            Optional macro SHIFTER_ROTATE_EN: op 11 rotates right (else SRL).
// Revision : 1.0  initial release
// ============================================================================
module pipelined_barrel_shifter #(
    parameter int WIDTH       = 32,
    parameter int PIPE_STAGES = 2
) (
    input  wire logic                 clk,
    input  wire logic                 reset,
    pipelined_barrel_shifter_if.slave bus
);
    localparam int SHW   = $clog2(WIDTH);
    localparam int LAST  = PIPE_STAGES - 1;
    localparam int BASE  = SHW / PIPE_STAGES;
    localparam int EXTRA = SHW % PIPE_STAGES;

    // Earlier stages absorb the leftover levels when SHW does not divide evenly.
    function automatic int lvl_first(input int k);
        return k * BASE + ((k < EXTRA) ? k : EXTRA);
    endfunction

    function automatic int lvl_count(input int k);
        return BASE + ((k < EXTRA) ? 1 : 0);
    endfunction

    function automatic logic [WIDTH-1:0] shift_level(
        input logic [WIDTH-1:0] d,
        input logic             sgn,
        input logic [1:0]       op,
        input int               s
    );
        logic [WIDTH-1:0] r;
        r = d >> s;
        case (op)
            2'b00:   r = d << s;
            2'b10:   r = r | ({WIDTH{sgn}} << (WIDTH - s));
`ifdef SHIFTER_ROTATE_EN
            2'b11:   r = r | (d << (WIDTH - s));
`endif
            default: r = d >> s;
        endcase
        return r;
    endfunction

    logic [PIPE_STAGES-1:0]            valid_q, valid_d;
    logic [PIPE_STAGES-1:0][WIDTH-1:0] data_q,  data_d;
    logic [PIPE_STAGES-1:0][SHW-1:0]   shamt_q, shamt_d;
    logic [PIPE_STAGES-1:0][1:0]       op_q,    op_d;
    logic [PIPE_STAGES-1:0][3:0]       tag_q,   tag_d;
    logic [PIPE_STAGES-1:0]            sign_q,  sign_d;

    logic [PIPE_STAGES-1:0]            w_load;
    logic [PIPE_STAGES-1:0]            w_src_valid;
    logic [PIPE_STAGES-1:0][WIDTH-1:0] w_src_data;
    logic [PIPE_STAGES-1:0][SHW-1:0]   w_src_shamt;
    logic [PIPE_STAGES-1:0][1:0]       w_src_op;
    logic [PIPE_STAGES-1:0][3:0]       w_src_tag;
    logic [PIPE_STAGES-1:0]            w_src_sign;
    logic                              w_unused_tail;

    // The SRA fill bit is taken from the original operand and travels with it.
    assign w_src_valid[0] = bus.in_valid;
    assign w_src_data[0]  = bus.in_data;
    assign w_src_shamt[0] = bus.in_shamt;
    assign w_src_op[0]    = bus.in_op;
    assign w_src_tag[0]   = bus.in_tag;
    assign w_src_sign[0]  = bus.in_data[WIDTH-1];

    for (genvar k = 1; k < PIPE_STAGES; k++) begin : g_link
        assign w_src_valid[k] = valid_q[k-1];
        assign w_src_data[k]  = data_q[k-1];
        assign w_src_shamt[k] = shamt_q[k-1];
        assign w_src_op[k]    = op_q[k-1];
        assign w_src_tag[k]   = tag_q[k-1];
        assign w_src_sign[k]  = sign_q[k-1];
    end

    always_comb begin
        w_load       = '0;
        w_load[LAST] = !valid_q[LAST] || bus.out_ready;
        for (int k = LAST - 1; k >= 0; k--) begin
            w_load[k] = !valid_q[k] || w_load[k+1];
        end
    end

    always_comb begin : p_stage_next
        logic [WIDTH-1:0] acc;
        acc     = '0;
        valid_d = valid_q;
        data_d  = data_q;
        shamt_d = shamt_q;
        op_d    = op_q;
        tag_d   = tag_q;
        sign_d  = sign_q;
        for (int k = 0; k < PIPE_STAGES; k++) begin
            acc = w_src_data[k];
            for (int l = 0; l < SHW; l++) begin
                if (l >= lvl_first(k) && l < lvl_first(k) + lvl_count(k) && w_src_shamt[k][l]) begin
                    acc = shift_level(acc, w_src_sign[k], w_src_op[k], 1 << l);
                end
            end
            if (w_load[k]) begin
                valid_d[k] = w_src_valid[k];
                if (w_src_valid[k]) begin
                    data_d[k]  = acc;
                    shamt_d[k] = w_src_shamt[k];
                    op_d[k]    = w_src_op[k];
                    tag_d[k]   = w_src_tag[k];
                    sign_d[k]  = w_src_sign[k];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            data_q  <= '0;
            shamt_q <= '0;
            op_q    <= '0;
            tag_q   <= '0;
            sign_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            shamt_q <= shamt_d;
            op_q    <= op_d;
            tag_q   <= tag_d;
            sign_q  <= sign_d;
        end
    end

    assign bus.in_ready  = w_load[0];
    assign bus.out_valid = valid_q[LAST];
    assign bus.out_data  = data_q[LAST];
    assign bus.out_tag   = tag_q[LAST];

    // Control fields of the final stage have no consumer.
    assign w_unused_tail = ^{shamt_q[LAST], op_q[LAST], sign_q[LAST]};
endmodule
`default_nettype wire

// File: tb/tb_pipelined_barrel_shifter.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipelined_barrel_shifter
// Brief    : Self-checking bench for pipelined_barrel_shifter (WIDTH 32, 2 stages).
// Revision : 1.0  initial release
// ============================================================================
module tb_pipelined_barrel_shifter;
    localparam int W      = 32;
    localparam int STAGES = 2;

    typedef struct packed {
        logic [W-1:0] data;
        logic [3:0]   tag;
    } res_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_pass  = 0;
    int   n_total = 0;
    int   cyc     = 0;
    res_t exp_q[$];
    res_t got_q[$];
    int   got_cyc[$];

    pipelined_barrel_shifter_if #(.WIDTH(W)) bus ();

    pipelined_barrel_shifter #(.WIDTH(W), .PIPE_STAGES(STAGES)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] model(input logic [W-1:0] d, input logic [4:0] s, input logic [1:0] op);
`ifdef SHIFTER_ROTATE_EN
        logic [2*W-1:0] dd;
        dd = {d, d} >> s;
`endif
        case (op)
            2'b00:   return d << s;
            2'b10:   return $signed(d) >>> s;
`ifdef SHIFTER_ROTATE_EN
            2'b11:   return dd[W-1:0];
`endif
            default: return d >> s;
        endcase
    endfunction

    task automatic rand_op(input logic [3:0] tag);
        bus.in_data  = $urandom();
        bus.in_shamt = 5'($urandom_range(0, 31));
        bus.in_op    = 2'($urandom_range(0, 3));
        bus.in_tag   = tag;
    endtask

    // Called at a falling edge once inputs are set; records handshakes of the coming rising edge.
    task automatic step(output logic acc);
        #1;
        acc = bus.in_valid && bus.in_ready;
        if (acc) exp_q.push_back(res_t'{model(bus.in_data, bus.in_shamt, bus.in_op), bus.in_tag});
        if (bus.out_valid && bus.out_ready) begin
            got_q.push_back(res_t'{bus.out_data, bus.out_tag});
            got_cyc.push_back(cyc);
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic clear_q();
        exp_q.delete();
        got_q.delete();
        got_cyc.delete();
    endtask

    task automatic test_reset();
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_shamt  = '0;
        bus.in_op     = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        n_total++;
        if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid);
        else n_pass++;
        n_total++;
        if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready);
        else n_pass++;
        n_total++;
        if (bus.out_data !== '0) $display("FAIL reset_out_data: got %h expected 0", bus.out_data);
        else n_pass++;
        n_total++;
        if (bus.out_tag !== 4'h0) $display("FAIL reset_out_tag: got %h expected 0", bus.out_tag);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [W-1:0] v_data [4];
        logic [4:0]   v_sh   [4];
        logic [1:0]   v_op   [4];
        logic [W-1:0] v_exp  [4];
        logic         acc;
        int           lat;
        v_data = '{32'h0000_0001, 32'h8000_00F0, 32'h8000_00F0, 32'h0000_00F1};
        v_sh   = '{5'd31, 5'd4, 5'd4, 5'd4};
        v_op   = '{2'b00, 2'b10, 2'b01, 2'b11};
        v_exp  = '{32'h8000_0000, 32'hF800_000F, 32'h0800_000F, 32'h0000_000F};
`ifdef SHIFTER_ROTATE_EN
        v_exp[3] = 32'h1000_000F;
`endif
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = v_data[i];
            bus.in_shamt = v_sh[i];
            bus.in_op    = v_op[i];
            bus.in_tag   = 4'(i + 9);
            step(acc);
            bus.in_valid = 1'b0;
            n_total++;
            if (acc !== 1'b1) $display("FAIL directed_accept[%0d]: got %b expected 1", i, acc);
            else n_pass++;
            lat = 1;
            #1;
            while (!bus.out_valid && lat < 20) begin
                @(negedge clk);
                #1;
                lat++;
            end
            n_total++;
            if (lat != STAGES) $display("FAIL directed_latency[%0d]: got %0d expected %0d", i, lat, STAGES);
            else n_pass++;
            n_total++;
            if (bus.out_data !== v_exp[i]) $display("FAIL directed_data[%0d]: got %h expected %h", i, bus.out_data, v_exp[i]);
            else n_pass++;
            n_total++;
            if (bus.out_tag !== 4'(i + 9)) $display("FAIL directed_tag[%0d]: got %h expected %h", i, bus.out_tag, 4'(i + 9));
            else n_pass++;
            @(negedge clk);
            clear_q();
        end
    endtask

    task automatic test_back_to_back();
        logic acc;
        int   c0;
        int   guard;
        bus.out_ready = 1'b1;
        c0 = cyc;
        for (int i = 0; i < 8; i++) begin
            bus.in_valid = 1'b1;
            rand_op(4'(i));
            step(acc);
            n_total++;
            if (acc !== 1'b1) $display("FAIL b2b_accept[%0d]: got %b expected 1", i, acc);
            else n_pass++;
        end
        bus.in_valid = 1'b0;
        guard = 0;
        while (got_q.size() < 8 && guard < 20) begin
            step(acc);
            guard++;
        end
        n_total++;
        if (got_q.size() != 8) $display("FAIL b2b_count: got %0d expected 8", got_q.size());
        else n_pass++;
        for (int i = 0; i < got_q.size() && i < 8; i++) begin
            n_total++;
            if (got_q[i] !== exp_q[i]) $display("FAIL b2b_result[%0d]: got %h expected %h", i, got_q[i], exp_q[i]);
            else n_pass++;
            n_total++;
            if (got_q[i].tag !== 4'(i)) $display("FAIL b2b_tag[%0d]: got %h expected %h", i, got_q[i].tag, 4'(i));
            else n_pass++;
            n_total++;
            if (got_cyc[i] != c0 + STAGES + i) $display("FAIL b2b_cycle[%0d]: got %0d expected %0d", i, got_cyc[i], c0 + STAGES + i);
            else n_pass++;
        end
        clear_q();
    endtask

    task automatic test_backpressure();
        logic         acc;
        int           guard;
        logic [W-1:0] hd;
        logic [3:0]   ht;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        rand_op(4'h3);
        guard = 0;
        do begin
            step(acc);
            if (acc) rand_op(4'(4 + exp_q.size()));
            guard++;
        end while (bus.in_ready && guard < 10);
        n_total++;
        if (exp_q.size() != STAGES) $display("FAIL bp_fill_count: got %0d expected %0d", exp_q.size(), STAGES);
        else n_pass++;
        #1;
        hd = bus.out_data;
        ht = bus.out_tag;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1;
            n_total++;
            if (bus.in_ready !== 1'b0) $display("FAIL bp_in_ready[%0d]: got %b expected 0", c, bus.in_ready);
            else n_pass++;
            n_total++;
            if (bus.out_valid !== 1'b1) $display("FAIL bp_out_valid[%0d]: got %b expected 1", c, bus.out_valid);
            else n_pass++;
            n_total++;
            if ({bus.out_data, bus.out_tag} !== {hd, ht}) $display("FAIL bp_stable[%0d]: got %h/%h expected %h/%h", c, bus.out_data, bus.out_tag, hd, ht);
            else n_pass++;
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        step(acc);
        n_total++;
        if (acc !== 1'b1) $display("FAIL bp_simultaneous_accept: got %b expected 1", acc);
        else n_pass++;
        bus.in_valid = 1'b0;
        guard = 0;
        while (got_q.size() < exp_q.size() && guard < 20) begin
            step(acc);
            guard++;
        end
        repeat (3) step(acc);
        n_total++;
        if (got_q.size() != STAGES + 1) $display("FAIL bp_count: got %0d expected %0d", got_q.size(), STAGES + 1);
        else n_pass++;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_total++;
            if (got_q[i] !== exp_q[i]) $display("FAIL bp_result[%0d]: got %h expected %h", i, got_q[i], exp_q[i]);
            else n_pass++;
        end
        clear_q();
    endtask

    task automatic test_random();
        logic acc;
        int   guard;
        for (int i = 0; i < 120; i++) begin
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.out_ready = ($urandom_range(0, 3) != 0);
            rand_op(4'($urandom()));
            step(acc);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        guard = 0;
        while (got_q.size() < exp_q.size() && guard < 20) begin
            step(acc);
            guard++;
        end
        repeat (3) step(acc);
        n_total++;
        if (got_q.size() != exp_q.size()) $display("FAIL rand_count: got %0d expected %0d", got_q.size(), exp_q.size());
        else n_pass++;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_total++;
            if (got_q[i] !== exp_q[i]) $display("FAIL rand_result[%0d]: got %h expected %h", i, got_q[i], exp_q[i]);
            else n_pass++;
        end
        clear_q();
    endtask

    task automatic test_reset_midflight();
        logic acc;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.in_valid = 1'b1;
            rand_op(4'(i + 1));
            step(acc);
            n_total++;
            if (acc !== 1'b1) $display("FAIL midrst_accept[%0d]: got %b expected 1", i, acc);
            else n_pass++;
        end
        bus.in_valid = 1'b0;
        reset        = 1'b1;
        @(negedge clk);
        #1;
        n_total++;
        if (bus.out_valid !== 1'b0) $display("FAIL midrst_out_valid: got %b expected 0", bus.out_valid);
        else n_pass++;
        n_total++;
        if (bus.in_ready !== 1'b1) $display("FAIL midrst_in_ready: got %b expected 1", bus.in_ready);
        else n_pass++;
        n_total++;
        if (bus.out_data !== '0) $display("FAIL midrst_out_data: got %h expected 0", bus.out_data);
        else n_pass++;
        reset = 1'b0;
        clear_q();
        bus.out_ready = 1'b1;
        @(negedge clk);
        repeat (10) step(acc);
        n_total++;
        if (got_q.size() != 0) $display("FAIL midrst_stale: got %0d results expected 0", got_q.size());
        else n_pass++;
        clear_q();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_random();
        test_reset_midflight();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
